// File: rtl/frame_rx_loader.sv
// Framed command parser: FE LEN CMD PAYLOAD EF from UART RX bytes,
// sets N, streams operands into FIFOs and issues the processor start.
module frame_rx_loader #(
  parameter int MAX_N = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_valid,
  input  logic [DW-1:0] rx_data,
  input  logic          busy,
  output logic [3:0]    N,
  output logic          push_mat,
  output logic [3:0]    push_row,
  output logic          push_vec,
  output logic [DW-1:0] push_data,
  output logic          clr_fifo,
  output logic          start,
  output logic          frame_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_CMD  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_FOOT = 3'd4;

  localparam logic [7:0] HDR = 8'hFE;
  localparam logic [7:0] FTR = 8'hEF;

  localparam logic [7:0] C_SETN  = 8'h01;
  localparam logic [7:0] C_CLR   = 8'h02;
  localparam logic [7:0] C_START = 8'h03;
  localparam logic [7:0] C_MAT   = 8'h04;
  localparam logic [7:0] C_VEC   = 8'h05;

  logic [2:0] state;
  logic [7:0] len;
  logic [7:0] cmd;
  logic [7:0] cnt;
  logic [7:0] pend;
  logic [3:0] col;
  logic [3:0] row;
  logic       mat_ok;
  logic       vec_ok;
  logic       pushed;

  logic [7:0] b;
  logic [7:0] n8;
  logic [7:0] nsq;
  logic       cmd_ok;
  logic       pend_ok;
  logic       can_start;

  assign b         = 8'(rx_data);
  assign n8        = {4'd0, N};
  assign nsq       = n8 * n8;
  assign pend_ok   = (pend != 8'd0) && (pend <= 8'(MAX_N));
  assign can_start = mat_ok && vec_ok && !busy;

  // Length/command legality, judged on the CMD byte itself.
  always_comb begin
    cmd_ok = 1'b0;
    unique case (1'b1)
      (b == C_SETN):  cmd_ok = (len == 8'd2) && !busy;
      (b == C_CLR):   cmd_ok = (len == 8'd1) && !busy;
      (b == C_START): cmd_ok = (len == 8'd1);
      (b == C_MAT):   cmd_ok = (N != 4'd0) && !busy &&
                               (len == nsq + 8'd1);
      (b == C_VEC):   cmd_ok = (N != 4'd0) && !busy &&
                               (len == n8 + 8'd1);
      default:        cmd_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      len       <= 8'd0;
      cmd       <= 8'd0;
      cnt       <= 8'd0;
      pend      <= 8'd0;
      col       <= 4'd0;
      row       <= 4'd0;
      mat_ok    <= 1'b0;
      vec_ok    <= 1'b0;
      pushed    <= 1'b0;
      N         <= 4'd0;
      push_mat  <= 1'b0;
      push_row  <= 4'd0;
      push_vec  <= 1'b0;
      push_data <= '0;
      clr_fifo  <= 1'b0;
      start     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      push_mat  <= 1'b0;
      push_row  <= 4'd0;
      push_vec  <= 1'b0;
      push_data <= '0;
      clr_fifo  <= 1'b0;
      start     <= 1'b0;
      frame_err <= 1'b0;
      if (rx_valid) begin
        case (state)
          S_IDLE: begin
            if (b == HDR)
              state <= S_LEN;
          end
          S_LEN: begin
            len <= b;
            if (b == 8'd0) begin
              frame_err <= 1'b1;
              state     <= S_IDLE;
            end else begin
              state <= S_CMD;
            end
          end
          S_CMD: begin
            cmd    <= b;
            col    <= 4'd0;
            row    <= 4'd0;
            pushed <= 1'b0;
            cnt    <= len - 8'd1;
            if (!cmd_ok) begin
              frame_err <= 1'b1;
              state     <= S_IDLE;
            end else if (len == 8'd1) begin
              state <= S_FOOT;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            if (cmd == C_SETN) begin
              pend <= b;
            end else if (cmd == C_MAT) begin
              push_mat  <= 1'b1;
              push_row  <= row;
              push_data <= rx_data;
              pushed    <= 1'b1;
              // Row-major fill: column wraps at N-1.
              if (col == N - 4'd1) begin
                col <= 4'd0;
                row <= row + 4'd1;
              end else begin
                col <= col + 4'd1;
              end
            end else begin
              push_vec  <= 1'b1;
              push_data <= rx_data;
              pushed    <= 1'b1;
            end
            cnt <= cnt - 8'd1;
            if (cnt == 8'd1)
              state <= S_FOOT;
          end
          S_FOOT: begin
            state <= S_IDLE;
            if (b == FTR) begin
              unique case (1'b1)
                (cmd == C_SETN): begin
                  if (pend_ok) begin
                    N        <= pend[3:0];
                    mat_ok   <= 1'b0;
                    vec_ok   <= 1'b0;
                    clr_fifo <= 1'b1;
                  end else begin
                    frame_err <= 1'b1;
                  end
                end
                (cmd == C_CLR): begin
                  clr_fifo <= 1'b1;
                  mat_ok   <= 1'b0;
                  vec_ok   <= 1'b0;
                end
                (cmd == C_MAT): mat_ok <= 1'b1;
                (cmd == C_VEC): vec_ok <= 1'b1;
                (cmd == C_START): begin
                  if (can_start) begin
                    start  <= 1'b1;
                    mat_ok <= 1'b0;
                    vec_ok <= 1'b0;
                  end else begin
                    frame_err <= 1'b1;
                  end
                end
                default: frame_err <= 1'b1;
              endcase
            end else begin
              frame_err <= 1'b1;
              // A half-loaded operand set must not survive.
              if (pushed) begin
                clr_fifo <= 1'b1;
                mat_ok   <= 1'b0;
                vec_ok   <= 1'b0;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_rx_loader.sv
// Scoreboard bench for frame_rx_loader: expected output events are
// queued with the stimulus and matched by an independent monitor.
module tb_frame_rx_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       busy = 1'b0;
  logic [3:0] N;
  logic       push_mat;
  logic [3:0] push_row;
  logic       push_vec;
  logic [7:0] push_data;
  logic       clr_fifo;
  logic       start;
  logic       frame_err;

  frame_rx_loader #(.MAX_N(8), .DW(8)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .busy(busy), .N(N), .push_mat(push_mat), .push_row(push_row),
    .push_vec(push_vec), .push_data(push_data), .clr_fifo(clr_fifo),
    .start(start), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pm;
    logic       pv;
    logic [3:0] row;
    logic [7:0] data;
    logic       clr;
    logic       st;
    logic       err;
    logic [3:0] n;
  } ev_t;

  typedef logic [7:0] bq_t[$];

  ev_t        q[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] en = 4'd0;
  bq_t        f;

  function automatic ev_t mk(input logic pm, input logic pv,
                             input logic [3:0] r, input logic [7:0] d,
                             input logic c, input logic s,
                             input logic e);
    ev_t x;
    x.pm = pm; x.pv = pv; x.row = r; x.data = d;
    x.clr = c; x.st = s; x.err = e; x.n = en;
    return x;
  endfunction

  task automatic e_pm(input logic [3:0] r, input logic [7:0] d);
    q.push_back(mk(1, 0, r, d, 0, 0, 0));
  endtask
  task automatic e_pv(input logic [7:0] d);
    q.push_back(mk(0, 1, 4'd0, d, 0, 0, 0));
  endtask
  task automatic e_clr();
    q.push_back(mk(0, 0, 4'd0, 8'd0, 1, 0, 0));
  endtask
  task automatic e_st();
    q.push_back(mk(0, 0, 4'd0, 8'd0, 0, 1, 0));
  endtask
  task automatic e_err();
    q.push_back(mk(0, 0, 4'd0, 8'd0, 0, 0, 1));
  endtask
  task automatic e_errclr();
    q.push_back(mk(0, 0, 4'd0, 8'd0, 1, 0, 1));
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic tx(input bq_t bs);
    foreach (bs[i]) send(bs[i]);
  endtask

  task automatic chk(input string nm, input logic [7:0] a,
                     input logic [7:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, a, x);
    end
  endtask

  task automatic chk_reset();
    chk("rst_push_mat", 8'(push_mat), 8'h00);
    chk("rst_push_vec", 8'(push_vec), 8'h00);
    chk("rst_clr_fifo", 8'(clr_fifo), 8'h00);
    chk("rst_start", 8'(start), 8'h00);
    chk("rst_frame_err", 8'(frame_err), 8'h00);
    chk("rst_N", 8'(N), 8'h00);
  endtask

  always @(negedge clk) begin
    ev_t a;
    ev_t e;
    if (rst && (push_mat || push_vec || clr_fifo || start || frame_err)) begin
      a.pm = push_mat; a.pv = push_vec; a.row = push_row;
      a.data = push_data; a.clr = clr_fifo; a.st = start;
      a.err = frame_err; a.n = N;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event act=%h", a);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL event act=%h exp=%h", a, e);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    rst = 1'b1;

    send(8'h12); send(8'hEF); send(8'h55);

    // T1
    en = 4'd3; e_clr();
    f = {8'hFE, 8'h02, 8'h01, 8'h03, 8'hEF}; tx(f);
    en = 4'd2; e_clr();
    f = {8'hFE, 8'h02, 8'h01, 8'h02, 8'hEF}; tx(f);

    // T2
    e_pm(0, 8'h0A); e_pm(0, 8'h0B); e_pm(1, 8'h0C); e_pm(1, 8'h0D);
    f = {8'hFE, 8'h05, 8'h04, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hEF}; tx(f);
    e_pv(8'h01); e_pv(8'h02);
    f = {8'hFE, 8'h03, 8'h05, 8'h01, 8'h02, 8'hEF}; tx(f);
    e_st();
    f = {8'hFE, 8'h01, 8'h03, 8'hEF}; tx(f);

    // T3
    e_pm(0, 8'h31); e_pm(0, 8'h32); e_pm(1, 8'h33); e_pm(1, 8'h34);
    f = {8'hFE, 8'h05, 8'h04, 8'h31, 8'h32, 8'h33, 8'h34, 8'hEF}; tx(f);
    e_err();
    f = {8'hFE, 8'h01, 8'h03, 8'hEF}; tx(f);
    e_pv(8'h41); e_pv(8'h42);
    f = {8'hFE, 8'h03, 8'h05, 8'h41, 8'h42, 8'hEF}; tx(f);
    busy = 1'b1;
    e_err();
    f = {8'hFE, 8'h01, 8'h03, 8'hEF}; tx(f);
    e_err();
    f = {8'hFE, 8'h05, 8'h04, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hEF}; tx(f);
    e_err();
    f = {8'hFE, 8'h01, 8'h02, 8'hEF}; tx(f);
    busy = 1'b0;
    e_st();
    f = {8'hFE, 8'h01, 8'h03, 8'hEF}; tx(f);

    // T4
    e_pv(8'h51); e_pv(8'h52);
    f = {8'hFE, 8'h03, 8'h05, 8'h51, 8'h52, 8'hEF}; tx(f);
    e_pm(0, 8'h61); e_pm(0, 8'h62); e_pm(1, 8'h63); e_pm(1, 8'h64);
    e_errclr();
    f = {8'hFE, 8'h05, 8'h04, 8'h61, 8'h62, 8'h63, 8'h64, 8'h00}; tx(f);
    e_err();
    f = {8'hFE, 8'h01, 8'h03, 8'hEF}; tx(f);

    // T5
    e_err();
    f = {8'hFE, 8'h02, 8'h01, 8'h09, 8'hEF}; tx(f);
    e_err();
    f = {8'hFE, 8'h03, 8'h04, 8'h0A, 8'h0B, 8'hEF}; tx(f);
    e_err();
    f = {8'hFE, 8'h00}; tx(f);
    e_err();
    f = {8'hFE, 8'h01, 8'h07, 8'hEF}; tx(f);
    e_pv(8'h11); e_pv(8'h22);
    f = {8'hFE, 8'h03, 8'h05, 8'h11, 8'h22, 8'hEF}; tx(f);

    // T6
    e_pm(0, 8'h0A); e_pm(0, 8'h0B);
    f = {8'hFE, 8'h05, 8'h04, 8'h0A, 8'h0B}; tx(f);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    en  = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    chk("queue_before_reset_drained", 8'(q.size()), 8'h00);
    rst = 1'b1;
    send(8'hAA);
    e_err();
    f = {8'hFE, 8'h01, 8'h04, 8'hEF}; tx(f);
    en = 4'd4; e_clr();
    f = {8'hFE, 8'h02, 8'h01, 8'h04, 8'hEF}; tx(f);
    e_pv(8'h01); e_pv(8'h02); e_pv(8'h03); e_pv(8'h04);
    f = {8'hFE, 8'h05, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'hEF}; tx(f);

    f = {8'hFE, 8'h11, 8'h04};
    for (int i = 0; i < 16; i++) begin
      e_pm(4'(i / 4), 8'(8'h20 + i));
      f.push_back(8'(8'h20 + i));
    end
    f.push_back(8'hEF);
    tx(f);
    e_st();
    f = {8'hFE, 8'h01, 8'h03, 8'hEF}; tx(f);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 8'(q.size()), 8'h00);
    chk("final_N", 8'(N), 8'h04);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
